mem_wb_buffer: RTL
==================

# mem_wb_buffer

Two-entry elastic pipeline register between the MEM stage and the WB stage of the 5-stage ARM pipeline. It captures the ALU result, the load data, the write-back select, the destination register and the write enable. It presents them to the 64-bit write-back 2:1 mux and to the register file write port. It also exports a resolved forwarding value for the EX-stage bypass network, and absorbs one cycle of WB back-pressure without dropping an instruction.

## Interface
- DATA_W, 64, datapath width
- REG_W, 5, register index width (X0–X31; X31 = XZR)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  buffer can accept this cycle
- in_alu_result  in  DATA_W  ALU/address result
- in_mem_data  in  DATA_W  data-memory read data
- in_mem_to_reg  in  1  1 = write back memory data, 0 = ALU result
- in_rd  in  REG_W  destination register
- in_reg_write  in  1  instruction writes the register file
- flush  in  1  synchronous squash of all held entries
- out_valid  out  1  head entry valid
- out_ready  in  1  WB/regfile consumes head this cycle
- out_alu_result, out_mem_data  out  DATA_W  head operands for the write-back mux (i0, i1)
- out_sel  out  1  head mem_to_reg, drives the write-back mux select
- out_rd  out  REG_W  head destination
- out_reg_write  out  1  head write enable, already qualified by out_valid
- fwd_valid  out  1  out_valid & out_reg_write
- fwd_rd  out  REG_W  = out_rd
- fwd_data  out  DATA_W  out_sel ? out_mem_data : out_alu_result
- occupancy  out  2  entries held (0–2)

## Operation
- Storage: head register H and skid register S, each with a valid bit. in_ready = ~S.valid, driven only from a registered state bit. Outputs are driven only from H.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Capture rule: if in_rd == 31, the stored reg_write is forced to 0 (XZR writes discarded). The data is still stored.
- States (encoded by the valid bits):
  - EMPTY (H=0,S=0):
    - in_fire → ONE, H ← input.
  - ONE (H=1,S=0):
    - in_fire & out_fire → ONE, H ← input.
    - in_fire & ~out_fire → FULL, S ← input.
    - ~in_fire & out_fire → EMPTY.
    - otherwise hold.
  - FULL (H=1,S=1): in_ready=0.
    - out_fire → ONE, H ← S.
    - otherwise hold.
- Order is strictly FIFO. No entry is ever duplicated or overwritten while valid.
- flush: next state is EMPTY regardless of in_fire/out_fire. An input captured that cycle is dropped. The current head may still be consumed that cycle (out_fire counts).
- out_reg_write = H.valid & H.reg_write. out_sel, out_rd and the data outputs are don't-care-stable: they hold their last value when invalid.
- occupancy = H.valid + S.valid.

## Timing
- rst_n low, asynchronous: H.valid=S.valid=0, all stored fields 0. Outputs are then out_valid=0, out_reg_write=0, fwd_valid=0, fwd_data=0, out_sel=0, out_rd=0, occupancy=0, in_ready=1.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: input captured at edge N appears on the outputs after edge N. One cycle from in_fire to out_valid when EMPTY or ONE-with-out_fire.
- Throughput: one instruction per cycle while out_ready=1.
- in_ready falls the cycle after the FULL transition. It rises the cycle after the first out_fire in FULL.
- fwd_* is combinational from H only. No forwarding from S, because S is never the oldest.

## Test plan
- Reset then stream: rst_n=0→1. Then 3 back-to-back inputs (alu=0x10,0x20,0x30; mem_to_reg=0; rd=1,2,3) with out_ready=1 → out_alu_result=0x10,0x20,0x30 on consecutive cycles, each 1 cycle after input, occupancy ≤1, in_ready=1 throughout.
- Back-pressure: out_ready=0 for 2 cycles while 3 inputs are offered → first two accepted, occupancy=2, in_ready=0, third held. After out_ready=1, outputs appear in order 1,2,3 with no loss or duplication.
- Write-back select: input alu=0xAAAA, mem=0x5555, mem_to_reg=1, rd=7, reg_write=1 → out_sel=1, fwd_valid=1, fwd_rd=7, fwd_data=0x5555. The same input with mem_to_reg=0 → fwd_data=0xAAAA.
- XZR suppression: rd=31, reg_write=1 → out_valid=1, out_reg_write=0, fwd_valid=0.
- Flush in FULL with simultaneous in_valid → next cycle occupancy=0, out_valid=0, in_ready=1, and the offered input never appears.
- Async reset mid-FULL: drop rst_n between edges → out_valid=0 and occupancy=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/mem_wb_buffer.sv
// Purpose: two-entry elastic MEM->WB pipeline register with head/skid storage and EX bypass tap.
// Latency: 1 cycle from in_fire to out_valid (empty, or one entry with head consumed same cycle).
// Backpressure: absorbs one stalled cycle in the skid entry; in_ready is a registered ~skid_valid.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        MEM-side handshake
//   in_alu_result, in_mem_data write-back mux operands captured from MEM
//   in_mem_to_reg, in_rd,      write-back select, destination register, write enable
//   in_reg_write
//   flush                      squash every held entry at the next edge
//   out_valid / out_ready      WB-side handshake, head entry only
//   out_alu_result,            head operands and select for the 64-bit write-back mux
//   out_mem_data, out_sel
//   out_rd, out_reg_write      register file write port (write enable qualified by out_valid)
//   fwd_valid/fwd_rd/fwd_data  resolved head result for the EX-stage bypass network
//   occupancy                  number of entries held (0..2)
module mem_wb_buffer #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic              in_mem_to_reg,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_reg_write,

    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_mem_data,
    output logic              out_sel,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_reg_write,

    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data,

    output logic [1:0]        occupancy
);

    // X31 is the zero register: writes to it are architecturally discarded.
    localparam logic [REG_W-1:0] XZR = REG_W'(31);

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
        logic              sel;
        logic [REG_W-1:0]  rd;
        logic              we;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '0;

    logic   h_vld;
    logic   s_vld;
    entry_t h_dat;
    entry_t s_dat;
    entry_t in_dat;
    logic   in_fire;
    logic   out_fire;

    // Data is stored unchanged for rd==XZR; only the write enable is dropped.
    always_comb begin
        in_dat     = ENTRY_ZERO;
        in_dat.alu = in_alu_result;
        in_dat.mem = in_mem_data;
        in_dat.sel = in_mem_to_reg;
        in_dat.rd  = in_rd;
        in_dat.we  = in_reg_write & (in_rd != XZR);
    end

    // Skid valid is a flop, so in_ready never combinationally depends on out_ready.
    assign in_ready = ~s_vld;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = h_vld & out_ready;

    // State is the pair {h_vld, s_vld}: 00 empty, 10 one entry, 11 full.
    // Payload registers are only loaded on a capture, so the outputs stay
    // stable while the head is invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_vld <= 1'b0;
            s_vld <= 1'b0;
            h_dat <= ENTRY_ZERO;
            s_dat <= ENTRY_ZERO;
        end else if (flush) begin
            // Any same-cycle capture is dropped; a consumed head is simply gone.
            h_vld <= 1'b0;
            s_vld <= 1'b0;
        end else begin
            case ({h_vld, s_vld})
                2'b00: begin
                    if (in_fire) begin
                        h_vld <= 1'b1;
                        h_dat <= in_dat;
                    end
                end
                2'b10: begin
                    if (in_fire && out_fire) begin
                        h_dat <= in_dat;
                    end else if (in_fire) begin
                        s_vld <= 1'b1;
                        s_dat <= in_dat;
                    end else if (out_fire) begin
                        h_vld <= 1'b0;
                    end
                end
                2'b11: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire) begin
                        h_dat <= s_dat;
                        s_vld <= 1'b0;
                    end
                end
                default: begin
                    // Skid without head is unreachable; recover to empty.
                    h_vld <= 1'b0;
                    s_vld <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid      = h_vld;
    assign out_alu_result = h_dat.alu;
    assign out_mem_data   = h_dat.mem;
    assign out_sel        = h_dat.sel;
    assign out_rd         = h_dat.rd;
    assign out_reg_write  = h_vld & h_dat.we;

    // Bypass only from the head: the skid entry is always younger.
    assign fwd_valid = out_reg_write;
    assign fwd_rd    = h_dat.rd;
    assign fwd_data  = h_dat.sel ? h_dat.mem : h_dat.alu;

    assign occupancy = {1'b0, h_vld} + {1'b0, s_vld};

endmodule
